board_ram_arbiter: RTL
======================

Name: board_ram_arbiter

Overview:
- Sequential arbiter owning the single port of the 2-bit x 128-entry game-board RAM.
- Shares the port between four requesters: initializer (0), flipper (1), validator (2), display/VGA reader (3).
- Replaces the static ctrl-select mux with a request/grant handshake, bounded hold time, and per-requester read-valid tagging.
- Sits between the requester blocks and gameboardRAM; drives the RAM address/data/wren and receives nothing back except timing knowledge.

Parameters:
- ADDR_W, 7, board address width.
- DATA_W, 2, cell data width.
- RD_LAT, 1, RAM read latency in cycles from address to valid q (1..3).
- MAX_HOLD, 64, consecutive cycles an owner may hold the grant while another request is pending (8..255).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- req  in  4  request per requester, index = requester id.
- addr_in  in  4*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W].
- data_in  in  4*DATA_W  packed write data, same packing.
- wren_in  in  4  write enable per requester.
- gnt  out  4  one-hot or zero grant.
- addr_out  out  ADDR_W  to RAM address.
- data_out  out  DATA_W  to RAM data.
- wren_out  out  1  to RAM wren.
- rd_valid  out  4  one-hot pulse: RAM q holds the read issued by requester i RD_LAT cycles earlier.
- busy  out  1  high while any grant is held.

Behaviour:
- Reset (reset==0 at a clock edge) clears: gnt=0, busy=0, rd_valid=0, hold counter=0, read pipeline=0, state=IDLE.
- Reset mid-operation aborts the current owner and flushes in-flight read tags; no rd_valid pulses afterwards.
- Combinational outputs while gnt==0: addr_out=0, data_out=0, wren_out=0.
- States:
  - IDLE: no owner.
  - OWN: gnt==one-hot(owner).
- Fixed priority: 0 > 1 > 2 > 3.
- IDLE: if any req is high, register gnt = highest-priority req and go to OWN. Grant appears 1 cycle after req.
- OWN, owner req still high, no preemption: hold gnt; hold counter increments, saturating at MAX_HOLD.
- OWN, owner drops req: the same edge re-arbitrates among the remaining reqs (no bubble cycle). Go to IDLE with gnt=0 if none are pending.
- Preemption: hold counter == MAX_HOLD-1 and any other req is high. At the next edge the grant moves to the highest-priority other requester; hold counter resets to 0. The preempted requester must keep req high to regain the grant later.
- Hold counter resets to 0 on every ownership change.
- Mux: addr_out/data_out/wren_out = owner's inputs, combinational from gnt. A requester may change address every cycle while granted; one access per cycle.
- Read tagging: each cycle with gnt[i]==1 and wren_in[i]==0, tag i enters a RD_LAT-deep shift register; the output drives rd_valid.
  - Tags survive preemption and owner release.
  - Writes produce no tag.
- Simultaneous events:
  - Owner release plus preemption in the same cycle: treated as a release.
  - A new higher-priority req does not preempt before MAX_HOLD is reached.
- Non-owners' wren_in is ignored and never reaches the RAM.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - Requester 0 keeps absolute priority.
  - Requesters 1-3 use round-robin: the search starts after the last granted of 1-3 (initial pointer = 3, so 1 wins first).
  - Pointer resets with reset.
- Undefined: fixed priority 0>1>2>3 as above; no pointer logic.

Test Plan:
- Reset hold: reset=0 for 3 cycles with req=4'b1111 -> gnt=0, wren_out=0, rd_valid=0 throughout; first gnt=4'b0001 one cycle after reset=1.
- Priority and zero-bubble handoff: req=4'b0110 -> gnt=4'b0010; drop req[1] -> next cycle gnt=4'b0100; drop req[2] -> gnt=0, busy=0.
- Write path: requester 1 granted, addr_in[1]=7'd27, data_in[1]=2'b10, wren_in[1]=1 -> addr_out=27, data_out=2'b10, wren_out=1 that cycle, no rd_valid.
- Read tagging with RD_LAT=1: requester 3 reads addr 0..3 on consecutive granted cycles -> rd_valid=4'b1000 on each following cycle; RAM preloaded with 0,1,2,1 gives q=0,1,2,1.
- Preemption with MAX_HOLD=8: requester 3 holds req for 20 cycles, requester 2 raises req at cycle 2 -> gnt switches to 4'b0100 exactly 8 cycles after requester 3's grant; returns to 4'b1000 after req[2] drops.
- With ARB_ROUND_ROBIN_EN: req=4'b1110 held, each owner drops and re-raises req after 1 access -> grant sequence 1,2,3,1; raising req[0] mid-sequence -> requester 0 wins the next arbitration.

Source files
------------

// File: rtl/board_ram_arbiter.sv
// Request/grant arbiter for the single port of the game-board RAM.
// Four requesters: 0 initializer, 1 flipper, 2 validator, 3 display reader.
// Fixed priority 0>1>2>3, bounded hold time with preemption, and per-requester
// read-valid tags delayed by the RAM read latency.
// Optional: define ARB_ROUND_ROBIN_EN to rotate priority among requesters 1-3
// (requester 0 keeps absolute priority).
module board_ram_arbiter #(
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned DATA_W   = 2,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned MAX_HOLD = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [3:0]            req,
  input  logic [4*ADDR_W-1:0]   addr_in,
  input  logic [4*DATA_W-1:0]   data_in,
  input  logic [3:0]            wren_in,
  output logic [3:0]            gnt,
  output logic [ADDR_W-1:0]     addr_out,
  output logic [DATA_W-1:0]     data_out,
  output logic                  wren_out,
  output logic [3:0]            rd_valid,
  output logic                  busy
);

  typedef enum logic [0:0] {StIdle, StOwn} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              owner_q, owner_d;
  logic [7:0]              hold_q, hold_d;
  logic [RD_LAT-1:0][3:0]  tag_q, tag_d;
  logic [3:0]              owner_oh;
  logic [3:0]              others;
  logic [3:0]              take_mask;
  logic                    take;

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] ptr_q, ptr_d;

  // Requester 0 first, then 1-3 starting just after the last granted of 1-3.
  function automatic logic [1:0] pick(input logic [3:0] m, input logic [1:0] ptr);
    logic [1:0] res;
    logic       found;
    logic [1:0] idx;
    res   = 2'd0;
    found = 1'b0;
    if (m[0]) begin
      found = 1'b1;
    end
    for (int unsigned k = 1; k <= 3; k++) begin
      idx = 2'(((32'(ptr) + k - 1) % 3) + 1);
      if (!found && m[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction
`else
  function automatic logic [1:0] pick(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction
`endif

  assign owner_oh = 4'b0001 << owner_q;
  assign others   = req & ~owner_oh;

  // Next-state: arbitration, release/handoff, hold counting and preemption.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    hold_d    = hold_q;
    take      = 1'b0;
    take_mask = req;
`ifdef ARB_ROUND_ROBIN_EN
    ptr_d     = ptr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (|req) take = 1'b1;
      end
      StOwn: begin
        if (!req[owner_q]) begin
          // Release re-arbitrates on the same edge; release wins over preemption.
          if (|req) begin
            take = 1'b1;
          end else begin
            state_d = StIdle;
            hold_d  = 8'd0;
          end
        end else if ((hold_q >= 8'(MAX_HOLD - 1)) && (|others)) begin
          take      = 1'b1;
          take_mask = others;
        end else if (hold_q != 8'(MAX_HOLD)) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (take) begin
      state_d = StOwn;
      hold_d  = 8'd0;
`ifdef ARB_ROUND_ROBIN_EN
      owner_d = pick(take_mask, ptr_q);
      if (owner_d != 2'd0) ptr_d = owner_d;
`else
      owner_d = pick(take_mask);
`endif
    end
  end

  // Outputs: grant from the registered owner, RAM port muxed from the owner.
  always_comb begin
    gnt      = 4'b0000;
    addr_out = '0;
    data_out = '0;
    wren_out = 1'b0;
    busy     = 1'b0;
    if (state_q == StOwn) begin
      gnt      = owner_oh;
      addr_out = addr_in[32'(owner_q)*ADDR_W +: ADDR_W];
      data_out = data_in[32'(owner_q)*DATA_W +: DATA_W];
      wren_out = wren_in[owner_q];
      busy     = 1'b1;
    end
  end

  // Read tag shift register: one stage per cycle of RAM read latency.
  always_comb begin
    tag_d[0] = gnt & ~wren_in;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  assign rd_valid = tag_q[RD_LAT-1];

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StIdle;
      owner_q <= 2'd0;
      hold_q  <= 8'd0;
      tag_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q   <= 2'd3;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      tag_q   <= tag_d;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

endmodule
